bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 Parameter MAX_OUTSTANDING, default 3, maximum accepted-but-unacknowledged target requests.
REQ-004 Clocking: the block SHALL use one clock, wb_clock_i; reset wb_reset_ni SHALL be asynchronous and active-low.
REQ-005 wb_clock_i  in  1  clock; all state changes on rising edge.
REQ-006 wb_reset_ni  in  1  asynchronous active-low reset.
REQ-007 window_i  in  1  high while the shared RAM bus is open to Wishbone (CPU slot closed).
REQ-008 {a,b}_cycle_i  in  1  initiator A (MCU bridge) / B (video fetch) bus cycle.
REQ-009 {a,b}_strobe_i, {a,b}_we_i  in  1 each  pipelined strobe, write enable.
REQ-010 {a,b}_addr_i  in  ADDR_WIDTH  address.
REQ-011 {a,b}_data_i  in  DATA_WIDTH  write data.
REQ-012 {a,b}_data_o  out  DATA_WIDTH  read data.
REQ-013 {a,b}_stall_o, {a,b}_ack_o  out  1 each  stall, acknowledge.
REQ-014 t_cycle_o, t_strobe_o, t_we_o  out  1 each  to RAM controller.
REQ-015 t_addr_o  out  ADDR_WIDTH; t_data_o  out  DATA_WIDTH  to RAM controller.
REQ-016 t_data_i  in  DATA_WIDTH; t_stall_i, t_ack_i  in  1 each  from RAM controller.
REQ-017 grant_o  out  2  one-hot owner (bit0 = A, bit1 = B), 00 when idle.
REQ-018 protocol_err_o  out  1  sticky stray-acknowledge flag.

Function
REQ-019 Registered state machine with states IDLE, OWN_A, OWN_B; grant_o SHALL decode the state.
REQ-020 IDLE: when window_i=1 and exactly one cycle_i is high, the next state SHALL grant that initiator.
REQ-021 IDLE with both cycles high and window_i=1: the initiator not granted last SHALL win; last_grant resets to B, so A wins first.
REQ-022 IDLE with window_i=0: no grant.
REQ-023 OWN_x: t_cycle_o, t_we_o, t_addr_o, and t_data_o SHALL combinationally follow owner x.
REQ-024 OWN_x: t_strobe_o = x_strobe_i & window_i & (outstanding < MAX_OUTSTANDING).
REQ-025 OWN_x: x_stall_o = t_stall_i | ~window_i | (outstanding == MAX_OUTSTANDING).
REQ-026 OWN_x: x_ack_o = t_ack_i, and x_data_o = t_data_i.
REQ-027 Non-owner: stall_o = 1, ack_o = 0, data_o = 0; in IDLE both stalls SHALL be 1 and all t_* outputs 0.
REQ-028 Outstanding counter: +1 on t_strobe_o & ~t_stall_i; -1 on t_ack_i; both in the same cycle SHALL leave it unchanged.
REQ-029 The counter SHALL never exceed MAX_OUTSTANDING.
REQ-030 t_ack_i with outstanding = 0 and no same-cycle acceptance SHALL be ignored (no underflow) and SHALL set protocol_err_o.
REQ-031 Ownership SHALL persist across window closures while the owner holds cycle_i; strobes are blocked while closed.
REQ-032 Owner dropping cycle_i: the next state SHALL be IDLE, outstanding SHALL clear, and t_cycle_o SHALL fall the same cycle.
REQ-033 Acknowledgements arriving after an owner drops cycle_i (abort) SHALL be discarded and SHALL NOT set protocol_err_o.
REQ-034 At least one IDLE cycle SHALL separate consecutive owners; grant latency from request is 1 cycle when window_i=1.

Reset
REQ-035 Asserting wb_reset_ni low SHALL immediately force state IDLE, last_grant=B, outstanding=0, and protocol_err_o=0.
REQ-036 While wb_reset_ni is low, all outputs SHALL be 0 except {a,b}_stall_o, which SHALL be 1.
REQ-037 Reset mid-transaction SHALL drop t_cycle_o asynchronously; first grant SHALL be possible 2 cycles after release.

Verification
REQ-038 Single request: A cycle+strobe, window_i=1 -> grant_o=01 next cycle; t_strobe_o=1; ack routed to a_ack_o; b_stall_o=1 throughout.
REQ-039 Contention: A and B request together from reset -> A granted; after A drops cycle, IDLE one cycle, then grant_o=10.
REQ-040 Backpressure: t_ack_i held 0 and 4 strobes from owner -> 3 accepted, 4th stalled until an ack arrives; counter never reaches 4.
REQ-041 Window close: window_i falls with outstanding=2 -> t_strobe_o=0 and stall=1; pending acks still delivered; ownership retained.
REQ-042 Stray ack: t_ack_i=1 in IDLE -> protocol_err_o=1 and held until reset.
REQ-043 Async reset while OWN_B with outstanding=2 -> t_cycle_o=0 and grant_o=00 without a clock edge.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two Wishbone initiators, the RAM controller and
// the arbiter.
//
//   window_i          shared RAM bus open to Wishbone (CPU slot closed)
//   a_* / b_*         initiator A (MCU bridge) and B (video fetch):
//                     cycle, strobe, we, addr, write data in;
//                     read data, stall, ack out
//   t_*               pipelined Wishbone port toward the RAM controller
//   grant_o           one-hot owner (bit0 = A, bit1 = B), 00 when idle
//   protocol_err_o    sticky stray-acknowledge flag
//
// modport slave  : the arbiter side
// modport master : the environment (initiators + RAM controller) side
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  window_i;

  logic                  a_cycle_i;
  logic                  a_strobe_i;
  logic                  a_we_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic [DATA_WIDTH-1:0] a_data_o;
  logic                  a_stall_o;
  logic                  a_ack_o;

  logic                  b_cycle_i;
  logic                  b_strobe_i;
  logic                  b_we_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic [DATA_WIDTH-1:0] b_data_o;
  logic                  b_stall_o;
  logic                  b_ack_o;

  logic                  t_cycle_o;
  logic                  t_strobe_o;
  logic                  t_we_o;
  logic [ADDR_WIDTH-1:0] t_addr_o;
  logic [DATA_WIDTH-1:0] t_data_o;
  logic [DATA_WIDTH-1:0] t_data_i;
  logic                  t_stall_i;
  logic                  t_ack_i;

  logic [1:0]            grant_o;
  logic                  protocol_err_o;

  modport slave (
    input  window_i,
    input  a_cycle_i, a_strobe_i, a_we_i, a_addr_i, a_data_i,
    output a_data_o, a_stall_o, a_ack_o,
    input  b_cycle_i, b_strobe_i, b_we_i, b_addr_i, b_data_i,
    output b_data_o, b_stall_o, b_ack_o,
    output t_cycle_o, t_strobe_o, t_we_o, t_addr_o, t_data_o,
    input  t_data_i, t_stall_i, t_ack_i,
    output grant_o, protocol_err_o
  );

  modport master (
    output window_i,
    output a_cycle_i, a_strobe_i, a_we_i, a_addr_i, a_data_i,
    input  a_data_o, a_stall_o, a_ack_o,
    output b_cycle_i, b_strobe_i, b_we_i, b_addr_i, b_data_i,
    input  b_data_o, b_stall_o, b_ack_o,
    input  t_cycle_o, t_strobe_o, t_we_o, t_addr_o, t_data_o,
    output t_data_i, t_stall_i, t_ack_i,
    input  grant_o, protocol_err_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-initiator Wishbone (pipelined) arbiter in front of a shared RAM
// controller. Initiator A (MCU bridge) and B (video fetch) compete for the
// bus whenever window_i is high; the owner keeps the bus until it drops its
// cycle, the per-owner count of accepted-but-unacknowledged requests is
// capped at MAX_OUTSTANDING, and a stray acknowledge sets a sticky flag.
//
// Ports:
//   wb_clock_i   clock, all state changes on the rising edge
//   wb_reset_ni  asynchronous active-low reset
//   bus          bus_arbiter_if.slave (initiators, RAM port, grant, error)
module bus_arbiter #(
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic         wb_clock_i,
  input  logic         wb_reset_ni,
  bus_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  // Acks still owed to aborted owners; generous headroom, saturating.
  localparam int ORPH_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Encoding chosen so the state register is directly the one-hot grant.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t            state;
  logic              last_b;        // 1: B was granted last
  logic              armed;         // first edge after reset release seen
  logic              protocol_err;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  cnt_next;
  logic [ORPH_W-1:0] orphan;
  logic [ORPH_W-1:0] orphan_next;

  function automatic logic [ORPH_W-1:0] sat_add(input logic [ORPH_W-1:0] base,
                                                input logic [CNT_W-1:0]  inc);
    logic [ORPH_W:0] sum;
    sum = {1'b0, base} + (ORPH_W + 1)'(inc);
    return sum[ORPH_W] ? {ORPH_W{1'b1}} : sum[ORPH_W-1:0];
  endfunction

  logic                  own_a;
  logic                  own_b;
  logic                  sel_cycle;
  logic                  sel_strobe;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  below_max;
  logic                  at_max;
  logic                  t_strobe;
  logic                  owner_stall;
  logic                  accept;
  logic                  ack_live;
  logic                  ack_orphan;
  logic                  stray;
  logic                  ack_count;
  logic                  owner_drop;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);

  // Owner mux toward the RAM controller; everything is zero in IDLE.
  always_comb begin
    sel_cycle  = 1'b0;
    sel_strobe = 1'b0;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    if (own_a) begin
      sel_cycle  = bus.a_cycle_i;
      sel_strobe = bus.a_strobe_i;
      sel_we     = bus.a_we_i;
      sel_addr   = bus.a_addr_i;
      sel_data   = bus.a_data_i;
    end else if (own_b) begin
      sel_cycle  = bus.b_cycle_i;
      sel_strobe = bus.b_strobe_i;
      sel_we     = bus.b_we_i;
      sel_addr   = bus.b_addr_i;
      sel_data   = bus.b_data_i;
    end
  end

  assign below_max   = (outstanding < CNT_MAX);
  assign at_max      = (outstanding >= CNT_MAX);
  assign t_strobe    = sel_strobe & bus.window_i & below_max;
  assign owner_stall = bus.t_stall_i | ~bus.window_i | at_max;
  assign accept      = t_strobe & ~bus.t_stall_i;

  // The RAM controller answers in order, so while acks are still owed to
  // an aborted owner the next acks belong to it and are swallowed here.
  assign ack_orphan  = bus.t_ack_i & (orphan != '0);
  assign ack_live    = bus.t_ack_i & (orphan == '0);
  // Ack with nothing pending and no same-cycle acceptance to pair with.
  assign stray       = ack_live & (outstanding == '0) & ~accept;
  assign ack_count   = ack_live & ~stray;
  assign owner_drop  = (own_a & ~bus.a_cycle_i) | (own_b & ~bus.b_cycle_i);

  always_comb begin
    cnt_next = outstanding;
    if (accept && !ack_count) begin
      cnt_next = outstanding + CNT_W'(1);
    end else if (!accept && ack_count) begin
      cnt_next = outstanding - CNT_W'(1);
    end
  end

  // On abort the owner's in-flight requests turn into owed acks.
  always_comb begin
    orphan_next = orphan - ORPH_W'(ack_orphan);
    if (owner_drop) begin
      orphan_next = sat_add(orphan_next, cnt_next);
    end
  end

  assign bus.t_cycle_o      = sel_cycle;
  assign bus.t_strobe_o     = t_strobe;
  assign bus.t_we_o         = sel_we;
  assign bus.t_addr_o       = sel_addr;
  assign bus.t_data_o       = sel_data;

  assign bus.a_stall_o      = own_a ? owner_stall : 1'b1;
  assign bus.a_ack_o        = own_a & ack_live;
  assign bus.a_data_o       = own_a ? bus.t_data_i : '0;
  assign bus.b_stall_o      = own_b ? owner_stall : 1'b1;
  assign bus.b_ack_o        = own_b & ack_live;
  assign bus.b_data_o       = own_b ? bus.t_data_i : '0;

  assign bus.grant_o        = state;
  assign bus.protocol_err_o = protocol_err;

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      armed        <= 1'b0;
      outstanding  <= '0;
      orphan       <= '0;
      protocol_err <= 1'b0;
    end else begin
      armed       <= 1'b1;
      orphan      <= orphan_next;
      outstanding <= cnt_next;
      if (stray) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          // No grant on the first edge after reset release.
          if (armed && bus.window_i) begin
            if (bus.a_cycle_i && (!bus.b_cycle_i || last_b)) begin
              state  <= OWN_A;
              last_b <= 1'b0;
            end else if (bus.b_cycle_i) begin
              state  <= OWN_B;
              last_b <= 1'b1;
            end
          end
        end
        OWN_A: begin
          if (!bus.a_cycle_i) begin
            state       <= IDLE;
            outstanding <= '0;
          end
        end
        OWN_B: begin
          if (!bus.b_cycle_i) begin
            state       <= IDLE;
            outstanding <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          outstanding <= '0;
        end
      endcase
    end
  end

endmodule
